// File: rtl/aes_round_scheduler_if.sv
// rtl/aes_round_scheduler_if.sv - request, round-datapath and result channels of the AES round scheduler
//
// Signals:
//   req0_*/req1_*  : two requesters (valid/ready/mode/data), mode 0=encrypt 1=decrypt
//   round_key_idx  : index into the expanded key schedule; round_key returns that key
//   rd_state/rd_mode/rd_last -> external round logic, rd_result <- its output
//   out_valid/out_ready/out_data/out_id/out_mode : result channel
//   busy           : scheduler is working on a block
// Modports: master = host/datapath side, slave = the scheduler.
interface aes_round_scheduler_if #(
    parameter int KIW = 4
);
    logic           req0_valid;
    logic           req0_ready;
    logic           req0_mode;
    logic [127:0]   req0_data;
    logic           req1_valid;
    logic           req1_ready;
    logic           req1_mode;
    logic [127:0]   req1_data;
    logic [KIW-1:0] round_key_idx;
    logic [127:0]   round_key;
    logic [127:0]   rd_state;
    logic           rd_mode;
    logic           rd_last;
    logic [127:0]   rd_result;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           out_id;
    logic           out_mode;
    logic           busy;

    modport master (
        output req0_valid, req0_mode, req0_data,
        output req1_valid, req1_mode, req1_data,
        input  req0_ready, req1_ready,
        input  round_key_idx, rd_state, rd_mode, rd_last,
        output round_key, rd_result,
        input  out_valid, out_data, out_id, out_mode, busy,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_mode, req0_data,
        input  req1_valid, req1_mode, req1_data,
        output req0_ready, req1_ready,
        output round_key_idx, rd_state, rd_mode, rd_last,
        input  round_key, rd_result,
        output out_valid, out_data, out_id, out_mode, busy,
        input  out_ready
    );
endinterface

// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - round-robin shared AES round controller (initial AddRoundKey + NR rounds)
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : aes_round_scheduler_if.slave (requesters, round datapath, result channel)
// Parameters:
//   NR  : number of AES rounds (1..14)
//   KIW : round-key index width, 2**KIW > NR
module aes_round_scheduler #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_round_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_t;

    localparam logic [KIW-1:0] NR_K = KIW'(NR);

    fsm_t           fsm;
    fsm_t           fsm_nxt;
    logic [127:0]   st;
    logic [KIW-1:0] rnd;
    logic           mode;
    logic           id;
    logic           prio;     // requester served last
    logic           grant0;
    logic           grant1;
    logic           last_rnd;

    // On a tie the requester that was not served last wins.
    assign grant0   = (fsm == IDLE) && bus.req0_valid && (!bus.req1_valid || prio);
    assign grant1   = (fsm == IDLE) && bus.req1_valid && (!bus.req0_valid || !prio);
    assign last_rnd = (rnd == NR_K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (grant0 || grant1) fsm_nxt = LOAD;
            LOAD:    fsm_nxt = ROUND;
            ROUND:   if (last_rnd) fsm_nxt = DONE;
            DONE:    if (bus.out_ready) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready    = grant0;
        bus.req1_ready    = grant1;
        bus.busy          = (fsm != IDLE);
        bus.out_valid     = (fsm == DONE);
        bus.out_data      = st;
        bus.out_id        = id;
        bus.out_mode      = mode;
        bus.rd_state      = st;
        bus.rd_mode       = mode;
        bus.rd_last       = 1'b0;
        bus.round_key_idx = '0;
        case (fsm)
            LOAD: begin
                // Decryption starts from the last round key and walks down.
                bus.round_key_idx = mode ? NR_K : '0;
            end
            ROUND: begin
                bus.round_key_idx = mode ? (NR_K - rnd) : rnd;
                bus.rd_last       = last_rnd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= '0;
            rnd  <= '0;
            mode <= 1'b0;
            id   <= 1'b0;
            prio <= 1'b1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (grant0) begin
                        st   <= bus.req0_data;
                        mode <= bus.req0_mode;
                        id   <= 1'b0;
                        prio <= 1'b0;
                    end else if (grant1) begin
                        st   <= bus.req1_data;
                        mode <= bus.req1_mode;
                        id   <= 1'b1;
                        prio <= 1'b1;
                    end
                end
                LOAD: begin
                    st  <= st ^ bus.round_key;
                    rnd <= KIW'(1);
                end
                ROUND: begin
                    st <= bus.rd_result;
                    if (!last_rnd) begin
                        rnd <= rnd + KIW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb/tb_aes_round_scheduler.sv - scoreboard bench for aes_round_scheduler with behavioural AES model
module tb_aes_round_scheduler;
    localparam int NR  = 10;
    localparam int KIW = 4;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_round_scheduler_if #(.KIW(KIW)) bus();
    aes_round_scheduler_if #(.KIW(KIW)) bus14();

    aes_round_scheduler #(.NR(NR), .KIW(KIW)) dut (.clk(clk), .reset(reset), .bus(bus));
    aes_round_scheduler #(.NR(14), .KIW(KIW)) dut14 (.clk(clk), .reset(reset), .bus(bus14));

    // ---------------- AES reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        int e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, a);
            a = gmul(a, a);
            e = e / 2;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x = gf_inv(b);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++)
            t[127-8*i -: 8] = sbox(gb(s, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4)));
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
                t[127-32*c -: 32] = {gmul(a0,2)^gmul(a1,3)^a2^a3, a0^gmul(a1,2)^gmul(a2,3)^a3,
                                     a0^a1^gmul(a2,2)^gmul(a3,3), gmul(a0,3)^a1^a2^gmul(a3,2)};
            end
        end
        return t ^ k;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++)
            t[127-8*i -: 8] = inv_sbox(gb(s, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)));
        t = t ^ k;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
                t[127-32*c -: 32] = {gmul(a0,14)^gmul(a1,11)^gmul(a2,13)^gmul(a3,9),
                                     gmul(a0,9)^gmul(a1,14)^gmul(a2,11)^gmul(a3,13),
                                     gmul(a0,13)^gmul(a1,9)^gmul(a2,14)^gmul(a3,11),
                                     gmul(a0,11)^gmul(a1,13)^gmul(a2,9)^gmul(a3,14)};
            end
        end
        return t;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round key idx of the expanded schedule; key is left-aligned, nk = key words.
    function automatic logic [127:0] rkey(input logic [255:0] key, input int nk, input int idx);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rc;
        if (idx > 14) idx = 14;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * idx + 4; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = xt(rc);
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] din, input logic [255:0] key,
                                            input int nk, input int nr, input logic dec);
        logic [127:0] s;
        if (!dec) begin
            s = din ^ rkey(key, nk, 0);
            for (int r = 1; r <= nr; r++) s = fwd_round(s, rkey(key, nk, r), r == nr);
        end else begin
            s = din ^ rkey(key, nk, nr);
            for (int r = nr - 1; r >= 0; r--) s = inv_round(s, rkey(key, nk, r), r == 0);
        end
        return s;
    endfunction

    // External key schedule and round datapath seen by each DUT.
    always_comb begin
        logic [127:0] k;
        k = rkey(KEY128, 4, int'(bus.round_key_idx));
        bus.round_key = k;
        bus.rd_result = bus.rd_mode ? inv_round(bus.rd_state, k, bus.rd_last)
                                    : fwd_round(bus.rd_state, k, bus.rd_last);
    end

    always_comb begin
        logic [127:0] k;
        k = rkey(KEY256, 8, int'(bus14.round_key_idx));
        bus14.round_key = k;
        bus14.rd_result = bus14.rd_mode ? inv_round(bus14.rd_state, k, bus14.rd_last)
                                        : fwd_round(bus14.rd_state, k, bus14.rd_last);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic         id;
        logic         mode;
        logic [127:0] din;
        logic [127:0] dout;
        int           acc;
    } exp_t;

    exp_t         sbq[$];
    logic         grant_log[$];
    int           acc_log[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           acc_cnt = 0;
    int           hs_cyc = 0;
    logic         served = 1'b1;
    logic [127:0] hs_data = '0;
    logic         hs_id = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic monitor_cycle();
        logic e0, e1, exp_valid, exp_last, exp_busy;
        logic [KIW-1:0] exp_idx;
        int j;
        exp_t h;
        e0 = 1'b0; e1 = 1'b0;
        if (sbq.size() == 0) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e0 = served; e1 = !served;
            end else begin
                e0 = bus.req0_valid; e1 = bus.req1_valid;
            end
        end
        chk("req0_ready", bus.req0_ready, e0);
        chk("req1_ready", bus.req1_ready, e1);
        if (e0 || e1) begin
            h.id   = e1;
            h.mode = e1 ? bus.req1_mode : bus.req0_mode;
            h.din  = e1 ? bus.req1_data : bus.req0_data;
            h.dout = cipher(h.din, KEY128, 4, NR, h.mode);
            h.acc  = cyc;
            sbq.push_back(h);
            served = e1;
            grant_log.push_back(e1);
            acc_log.push_back(cyc);
            acc_cnt++;
        end
        exp_idx = '0; exp_last = 1'b0; exp_valid = 1'b0; exp_busy = 1'b0;
        if (sbq.size() != 0) begin
            h = sbq[0];
            j = cyc - h.acc - 1;
            exp_busy = (j >= 0);
            if (j >= 0 && j <= NR) begin
                exp_idx  = KIW'(h.mode ? NR - j : j);
                exp_last = (j == NR);
            end
            if (j == 0) chk("rd_state_load", bus.rd_state, h.din);
            if (j >= 1 && j <= NR) chk("rd_mode", bus.rd_mode, h.mode);
            exp_valid = (j >= NR + 1);
        end
        chk("busy", bus.busy, exp_busy);
        chk("round_key_idx", bus.round_key_idx, exp_idx);
        chk("rd_last", bus.rd_last, exp_last);
        chk("out_valid", bus.out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_data", bus.out_data, h.dout);
            chk("out_id", bus.out_id, h.id);
            chk("out_mode", bus.out_mode, h.mode);
            if (bus.out_ready) begin
                void'(sbq.pop_front());
                hs_data = bus.out_data;
                hs_id   = bus.out_id;
                hs_cyc  = cyc;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) monitor_cycle();
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string nm);
        for (int t = 0; t < budget && acc_cnt < target; t++) step();
        chk(nm, acc_cnt >= target, 1'b1);
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget && sbq.size() != 0; t++) step();
        chk("drain", sbq.size(), 0);
    endtask

    task automatic clear_req();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic one_block(input logic rq, input logic md, input logic [127:0] d);
        int a0 = acc_cnt;
        if (rq) begin
            bus.req1_valid = 1'b1; bus.req1_mode = md; bus.req1_data = d;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_mode = md; bus.req0_data = d;
        end
        wait_acc(a0 + 1, 10, "one_block_accept");
        clear_req();
        drain(40);
    endtask

    task automatic run14(input logic rq, input logic md, input logic [127:0] din,
                         input logic [127:0] want, input string nm);
        int a = -1;
        int v = -1;
        step();
        if (rq) begin
            bus14.req1_valid = 1'b1; bus14.req1_mode = md; bus14.req1_data = din;
        end else begin
            bus14.req0_valid = 1'b1; bus14.req0_mode = md; bus14.req0_data = din;
        end
        for (int t = 0; t < 20 && a < 0; t++) begin
            @(negedge clk);
            if (rq ? bus14.req1_ready : bus14.req0_ready) a = cyc;
        end
        @(posedge clk);
        #1;
        bus14.req0_valid = 1'b0;
        bus14.req1_valid = 1'b0;
        for (int t = 0; t < 40 && v < 0; t++) begin
            @(negedge clk);
            if (bus14.out_valid) v = cyc;
        end
        chk({nm, "_seen"}, (a >= 0) && (v >= 0), 1'b1);
        chk({nm, "_latency"}, v - a, 16);
        chk({nm, "_data"}, bus14.out_data, want);
        chk({nm, "_id"}, bus14.out_id, rq);
        chk({nm, "_mode"}, bus14.out_mode, md);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bus.req0_valid = 0; bus.req0_mode = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_mode = 0; bus.req1_data = '0;
        bus.out_ready = 1'b1;
        bus14.req0_valid = 0; bus14.req0_mode = 0; bus14.req0_data = '0;
        bus14.req1_valid = 0; bus14.req1_mode = 0; bus14.req1_data = '0;
        bus14.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rd_last", bus.rd_last, 1'b0);
        chk("rst_idx", bus.round_key_idx, '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
        @(posedge clk);
        #2 reset = 1'b0;
        step();

        // FIPS-197 C.1 encrypt on req0, then decrypt on req1
        one_block(1'b0, 1'b0, PT);
        chk("enc_data", hs_data, CT);
        chk("enc_id", hs_id, 1'b0);
        one_block(1'b1, 1'b1, CT);
        chk("dec_data", hs_data, PT);
        chk("dec_id", hs_id, 1'b1);

        // both requesters continuously valid: alternating grants, NR+3 spacing
        a0 = acc_cnt;
        bus.req0_valid = 1; bus.req0_mode = 0; bus.req0_data = {$urandom, $urandom, $urandom, $urandom};
        bus.req1_valid = 1; bus.req1_mode = 1; bus.req1_data = {$urandom, $urandom, $urandom, $urandom};
        wait_acc(a0 + 4, 80, "arb_accept");
        clear_req();
        drain(40);
        for (int k = 0; k < 4; k++) chk("arb_grant", grant_log[a0 + k], k % 2);
        for (int k = 0; k < 3; k++) chk("arb_gap", acc_log[a0 + k + 1] - acc_log[a0 + k], NR + 3);

        // single requester granted back-to-back
        a0 = acc_cnt;
        bus.req0_valid = 1;
        wait_acc(a0 + 2, 40, "single_accept");
        clear_req();
        drain(40);
        chk("single_grant0", grant_log[a0], 1'b0);
        chk("single_grant1", grant_log[a0 + 1], 1'b0);
        chk("single_gap", acc_log[a0 + 1] - acc_log[a0], NR + 3);

        // backpressure for 20 cycles in DONE
        a0 = acc_cnt;
        bus.out_ready = 1'b0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        wait_acc(a0 + 1, 10, "bp_accept");
        for (int t = 0; t < 30 && cyc < acc_log[a0] + NR + 2; t++) step();
        repeat (20) step();
        bus.out_ready = 1'b1;
        wait_acc(a0 + 2, 10, "bp_regrant");
        clear_req();
        chk("bp_regrant_gap", acc_log[a0 + 1] - hs_cyc, 1);
        drain(40);

        // randomized traffic with random backpressure
        a0 = acc_cnt;
        for (int t = 0; t < 1200 && acc_cnt < a0 + 24; t++) begin
            bus.req0_valid = ($urandom_range(0, 1) == 1);
            bus.req1_valid = ($urandom_range(0, 1) == 1);
            bus.req0_mode  = $urandom_range(0, 1);
            bus.req1_mode  = $urandom_range(0, 1);
            bus.req0_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.req1_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rand_blocks", acc_cnt >= a0 + 24, 1'b1);
        clear_req();
        bus.out_ready = 1'b1;
        drain(40);

        // asynchronous reset during round 5
        a0 = acc_cnt;
        bus.req1_valid = 1; bus.req1_mode = 0; bus.req1_data = {$urandom, $urandom, $urandom, $urandom};
        wait_acc(a0 + 1, 10, "rst_mid_accept");
        clear_req();
        for (int t = 0; t < 20 && cyc < acc_log[a0] + 6; t++) step();
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_idx", bus.round_key_idx, '0);
        chk("midrst_rd_last", bus.rd_last, 1'b0);
        chk("midrst_out_data", bus.out_data, '0);
        chk("midrst_rd_state", bus.rd_state, '0);
        sbq.delete();
        served = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        step();
        a0 = acc_cnt;
        bus.req0_valid = 1; bus.req0_mode = 1; bus.req0_data = CT;
        bus.req1_valid = 1; bus.req1_mode = 0; bus.req1_data = PT;
        wait_acc(a0 + 1, 10, "post_rst_accept");
        clear_req();
        drain(40);
        chk("post_rst_tie_grant", grant_log[a0], 1'b0);
        chk("post_rst_data", hs_data, PT);

        // NR=14 instance, AES-256 FIPS-197 C.3
        run14(1'b0, 1'b0, PT, CT3, "aes256_enc");
        run14(1'b1, 1'b1, CT3, PT, "aes256_dec");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
Iterative AES round controller that shares one external round datapath (forward/inverse round logic) and one key-expansion round-key source between two requesters. It arbitrates round-robin and performs the initial AddRoundKey internally. It then steps the external round logic through NR rounds (last round flagged) and presents the result on a valid/ready output channel. It sits between host-side request logic and the round/keyExpansion datapath, replacing per-instance round counters in standalone encrypt/decrypt wrappers.

Parameters:
NR, 10, number of AES rounds (10/12/14); legal range 1..14
KIW, 4, width of round-key index; must satisfy 2^KIW > NR

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a block
req0_ready  out  1  requester 0 block accepted this cycle (grant)
req0_mode  in  1  0=encrypt, 1=decrypt
req0_data  in  128  plaintext/ciphertext, bit 127 = byte 0 MSB
req1_valid, req1_ready, req1_mode, req1_data  as requester 0
round_key_idx  out  KIW  index into expanded key schedule
round_key  in  128  key word for round_key_idx, combinational, same cycle
rd_state  out  128  state fed to external round logic (= internal state register)
rd_mode  out  1  0 selects forward round, 1 selects inverse round
rd_last  out  1  1 selects final-round variant (no (Inv)MixColumns)
rd_result  in  128  combinational round output for rd_state/round_key/rd_mode/rd_last
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  128  result block
out_id  out  1  requester that issued the block
out_mode  out  1  mode of the block
busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, LOAD, ROUND, DONE. Registers: fsm, st (128), rnd (KIW), mode, id, prio (1 = requester last served).
- Reset (async): fsm=IDLE, st=0, rnd=0, mode=0, id=0, prio=1. All outputs 0: out_valid, req*_ready, busy, rd_last, round_key_idx, out_data.
- Reset mid-operation aborts the block silently; no output is produced for it.
- IDLE: grant is combinational. If exactly one reqN_valid is high, reqN_ready=1. If both are high, grant the requester != prio. Readies are 0 outside IDLE.
- On the accept edge: capture data into st, capture mode and id, set prio=id, go to LOAD.
- LOAD (1 cycle): round_key_idx = mode ? NR : 0. Edge: st <= st ^ round_key, rnd=1, go to ROUND.
- ROUND: round_key_idx = mode ? NR-rnd : rnd. rd_mode=mode. rd_last=(rnd==NR). Each edge: st <= rd_result.
  - If rnd==NR, go to DONE; else rnd++.
- DONE: out_valid=1; out_data=st, out_id=id, out_mode=mode held stable until out_valid&&out_ready. On that edge go to IDLE.
  - No accept in the same cycle as DONE; a new grant is earliest in the following IDLE cycle.
- Latency: accept edge at cycle 0 gives out_valid high from cycle NR+2 (12 for NR=10). Throughput: one block per NR+3 cycles with out_ready tied high.
- round_key_idx=0 and rd_last=0 in IDLE and DONE; rd_state=st always.
- Request inputs changing while not granted have no effect. Inputs after acceptance are not resampled.
- busy=1 in LOAD, ROUND, DONE.

Test Plan:
- Encrypt FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, req0 mode 0 data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_id 0, out_valid at cycle 12 after accept. round_key_idx sequence 0,1..10; rd_last only in the idx-10 cycle.
- Decrypt: req1 mode 1 data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_id 1. round_key_idx sequence 10,9..0.
- Arbitration: both valid continuously after reset -> grants 0,1,0,1. A single active requester is granted back-to-back despite prio.
- Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid/out_data stable, both req*_ready=0; the next grant comes one cycle after the out handshake.
- Reset asserted asynchronously during round 5 -> outputs 0 immediately, fsm IDLE. The next request completes correctly and req0 wins a tie.
- NR=14 build with AES-256 C.3 vector (key 00..1f) -> 8ea2b7ca516745bfeafc49904b496089, out_valid 16 cycles after accept.
